instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Encoder counterpart to the main control decoder. Accepts one instruction request per cycle (operation plus register and immediate fields) on a valid/ready handshake.
- Packs each request into a 32-bit LEGv8 word (R, D or CB format).
- Writes the words sequentially into instruction memory through a write port. Used by the bench and boot loader to build programs for the single-cycle processor.

Parameters:
- ADDR_W, 6, width of the instruction-memory word address.
- DEPTH, 64, number of words that may be written; must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  encoder can accept a request this cycle.
- in_op  in  3  operation code: 0 LDUR, 1 STUR, 2 CBZ, 3 ADD, 4 SUB, 5 AND, 6 ORR, 7 illegal.
- in_rd  in  5  Rd (R-format) or Rt (LDUR/STUR/CBZ).
- in_rn  in  5  Rn.
- in_rm  in  5  Rm (R-format only).
- in_imm  in  19  signed immediate: D-format byte offset or CBZ word offset.
- wr_en  out  1  instruction-memory write strobe.
- wr_addr  out  ADDR_W  word address of the write; byte PC = 4*wr_addr.
- wr_data  out  32  encoded instruction.
- count  out  ADDR_W+1  number of words written so far.
- full  out  1  count == DEPTH.
- err  out  1  sticky error flag.

Behaviour:
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, count=0, full=0, err=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Handshake:
  - A request is accepted on a rising edge where in_valid && in_ready.
  - The request fields are sampled only at acceptance.
- in_ready = !full. Purely combinational from registered state; no combinational path from in_valid.
- Latency and throughput:
  - An accepted legal request at edge N produces wr_en=1 for exactly the cycle following edge N.
  - In that cycle, wr_addr = the previous write pointer and wr_data = the encoded word.
  - Back-to-back acceptance is allowed (throughput 1/cycle), so consecutive cycles give consecutive addresses.
- Encoding, bit 31 down to bit 0:
  - LDUR: 11111000010, imm[8:0], 00, Rn, Rt.
  - STUR: 11111000000, imm[8:0], 00, Rn, Rt.
  - CBZ: 10110100, imm[18:0], Rt.
  - ADD: 10001011000, Rm, 000000, Rn, Rd.
  - SUB: 11001011000, Rm, 000000, Rn, Rd.
  - AND: 10001010000, Rm, 000000, Rn, Rd.
  - ORR: 10101010000, Rm, 000000, Rn, Rd.
- Range check:
  - For LDUR/STUR, in_imm must lie in −256..255, i.e. imm[18:8] is all zeros or all ones.
  - Otherwise the request is illegal.
- Illegal requests (in_op=7 or an out-of-range D immediate):
  - Still accepted (handshake completes).
  - err goes to 1 the following cycle.
  - No write; pointer and count unchanged.
- err clears only on reset.
- State machine, two states:
  - LOAD: in_ready=1. A legal accept increments the pointer and count. If count reaches DEPTH, go to FULL.
  - FULL: full=1, in_ready=0; requests are stalled, not dropped. Exit only on reset.
- Pointer: the word write pointer equals count[ADDR_W-1:0] and never wraps. When DEPTH = 2**ADDR_W, count's extra bit represents DEPTH.
- wr_en is 0 on every cycle not directly following a legal acceptance. wr_addr and wr_data hold their last values when wr_en=0.
- Reset mid-stream: a reset asserted in the cycle in which wr_en would be 1 suppresses that write. All state returns to reset values.

Decomposition:
- Shared package instr_pkg holds:
  - The op enumeration (op_e, 3 bits).
  - The 11-bit opcode constants LDUR/STUR/ADD/SUB/AND/ORR.
  - The 8-bit CBZ opcode constant.
  The main decoder and this encoder use the same constants so they cannot diverge.
- One combinational sub-module, instr_pack: takes op and fields and returns word plus illegal flag. Testable standalone against the decoder.

Test Plan:
- Reset, then a single ADD (rd=1, rn=2, rm=3) -> next cycle wr_en=1, wr_addr=0, wr_data=0x8B030041; count=1.
- Back-to-back: LDUR (rt=5, rn=6, imm=−8), then STUR (rt=5, rn=6, imm=16), then CBZ (rt=5, imm=−2):
  - Three consecutive wr_en cycles at addresses 0, 1, 2.
  - Data 0xF85F80C5, 0xF80100C5, 0xB4FFFFC5.
- Illegal requests: op=7, then LDUR with imm=300 -> both accepted, err=1, no wr_en, count stays 0. A following SUB (rd=0, rn=0, rm=0) writes 0xCB000000 at address 0.
- Fill with DEPTH=4 using legal requests and in_valid held high:
  - After the 4th accept, full=1 and in_ready=0; the 5th request is stalled.
  - No 5th write; count=4.
- Reset asserted in the cycle after an accepted ORR (rd=1, rn=1, rm=1) -> wr_en=0 that cycle; count=0, err=0, in_ready=1 afterwards.
- Cross-check: feed each encoded word's bits [31:21] into the main control decoder -> control outputs match the expected LDUR/STUR/CBZ/R-type rows.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared LEGv8 opcode constants and the encoder's operation enumeration.
// The control decoder imports the same constants so the two cannot drift apart.
package instr_pkg;

    typedef enum logic [2:0] {
        OP_LDUR    = 3'd0,
        OP_STUR    = 3'd1,
        OP_CBZ     = 3'd2,
        OP_ADD     = 3'd3,
        OP_SUB     = 3'd4,
        OP_AND     = 3'd5,
        OP_ORR     = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

    // D-format offsets are 9-bit signed; the upper bits must be a pure sign extension.
    function automatic logic d_imm_in_range(input logic [18:0] imm);
        return (imm[18:8] == 11'h000) || (imm[18:8] == 11'h7ff);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: turns an operation plus register/immediate fields into
// one 32-bit LEGv8 word and flags requests that cannot be encoded.
module instr_pack
    import instr_pkg::*;
(
    input  op_e         op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [18:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        word    = 32'h0000_0000;
        illegal = 1'b0;
        case (op)
            OP_LDUR: begin
                word    = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
                illegal = !d_imm_in_range(imm);
            end
            OP_STUR: begin
                word    = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
                illegal = !d_imm_in_range(imm);
            end
            OP_CBZ:  word = {OPC_CBZ, imm, rd};
            OP_ADD:  word = {OPC_ADD, rm, 6'b000000, rn, rd};
            OP_SUB:  word = {OPC_SUB, rm, 6'b000000, rn, rd};
            OP_AND:  word = {OPC_AND, rm, 6'b000000, rn, rd};
            OP_ORR:  word = {OPC_ORR, rm, 6'b000000, rn, rd};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Accepts encode requests on a valid/ready handshake and streams the packed
// words into instruction memory at consecutive addresses until DEPTH is reached.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [18:0]       in_imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_e;

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    state_e      state;
    logic        wr_en_q;
    logic [31:0] packed_word;
    logic        packed_illegal;
    logic        accept;
    logic [ADDR_W:0] count_next;

    instr_pack u_pack (
        .op      (op_e'(in_op)),
        .rd      (in_rd),
        .rn      (in_rn),
        .rm      (in_rm),
        .imm     (in_imm),
        .word    (packed_word),
        .illegal (packed_illegal)
    );

    assign full       = (state == FULL);
    assign in_ready   = !full;
    assign accept     = in_valid && in_ready;
    assign count_next = count + 1'b1;

    // A reset landing in the write cycle must kill the strobe before memory sees it.
    assign wr_en = wr_en_q && !reset;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state   <= LOAD;
            wr_en_q <= 1'b0;
            wr_addr <= '0;
            wr_data <= 32'h0000_0000;
            count   <= '0;
            err     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (packed_illegal) begin
                            err <= 1'b1;
                        end else begin
                            wr_en_q <= 1'b1;
                            wr_addr <= count[ADDR_W-1:0];
                            wr_data <= packed_word;
                            count   <= count_next;
                            if (count_next == DEPTH_C) state <= FULL;
                        end
                    end
                end
                FULL:    state <= FULL;
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (DEPTH=4, ADDR_W=2) with a small reference
// main-control decoder used to cross-check the opcode fields of emitted words.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rd, in_rn, in_rm;
    logic [18:0] in_imm;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  count;
    logic        full;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [31:0] w_ldur, w_stur, w_cbz, w_add;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(2), .DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_rn    (in_rn),
        .in_rm    (in_rm),
        .in_imm   (in_imm),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .count    (count),
        .full     (full),
        .err      (err)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic [18:0] imm);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rn    = rn;
        in_rm    = rm;
        in_imm   = imm;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reference main control: {reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop[1:0]}
    function automatic logic [8:0] control_row(input logic [10:0] opc);
        casez (opc)
            11'b11111000010: return 9'b0_1_1_1_1_0_0_00;
            11'b11111000000: return 9'b1_1_0_0_0_1_0_00;
            11'b10110100???: return 9'b1_0_0_0_0_0_1_01;
            11'b1??0101?000: return 9'b0_0_0_1_0_0_0_10;
            default:         return 9'b0_0_0_0_0_0_0_00;
        endcase
    endfunction

    initial begin
        in_valid = 1'b0;
        in_op = 3'd0; in_rd = 5'd0; in_rn = 5'd0; in_rm = 5'd0; in_imm = 19'd0;
        w_ldur = 32'h0; w_stur = 32'h0; w_cbz = 32'h0; w_add = 32'h0;
        do_reset();

        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single ADD
        req(3'd3, 5'd1, 5'd2, 5'd3, 19'd0);
        tick();
        in_valid = 1'b0;
        check("add_wr_en", 32'(wr_en), 32'd1);
        check("add_wr_addr", 32'(wr_addr), 32'd0);
        check("add_wr_data", wr_data, 32'h8B030041);
        check("add_count", 32'(count), 32'd1);
        w_add = wr_data;
        tick();
        check("idle_wr_en", 32'(wr_en), 32'd0);
        check("idle_hold_data", wr_data, 32'h8B030041);
        check("idle_hold_addr", 32'(wr_addr), 32'd0);

        // Back-to-back LDUR / STUR / CBZ
        do_reset();
        req(3'd0, 5'd5, 5'd6, 5'd0, 19'h7FFF8);
        tick();
        check("ldur_wr_en", 32'(wr_en), 32'd1);
        check("ldur_wr_addr", 32'(wr_addr), 32'd0);
        check("ldur_wr_data", wr_data, 32'hF85F80C5);
        w_ldur = wr_data;
        req(3'd1, 5'd5, 5'd6, 5'd0, 19'd16);
        tick();
        check("stur_wr_en", 32'(wr_en), 32'd1);
        check("stur_wr_addr", 32'(wr_addr), 32'd1);
        check("stur_wr_data", wr_data, 32'hF80100C5);
        w_stur = wr_data;
        req(3'd2, 5'd5, 5'd0, 5'd0, 19'h7FFFE);
        tick();
        in_valid = 1'b0;
        check("cbz_wr_en", 32'(wr_en), 32'd1);
        check("cbz_wr_addr", 32'(wr_addr), 32'd2);
        check("cbz_wr_data", wr_data, 32'hB4FFFFC5);
        w_cbz = wr_data;
        tick();
        check("b2b_idle_wr_en", 32'(wr_en), 32'd0);
        check("b2b_count", 32'(count), 32'd3);

        // Illegal op, then out-of-range LDUR offset, then a legal SUB
        do_reset();
        req(3'd7, 5'd1, 5'd1, 5'd1, 19'd0);
        tick();
        check("ill_op_wr_en", 32'(wr_en), 32'd0);
        check("ill_op_err", 32'(err), 32'd1);
        check("ill_op_count", 32'(count), 32'd0);
        req(3'd0, 5'd1, 5'd1, 5'd0, 19'd300);
        tick();
        check("ill_imm_wr_en", 32'(wr_en), 32'd0);
        check("ill_imm_count", 32'(count), 32'd0);
        check("ill_imm_ready", 32'(in_ready), 32'd1);
        req(3'd4, 5'd0, 5'd0, 5'd0, 19'd0);
        tick();
        in_valid = 1'b0;
        check("sub_wr_en", 32'(wr_en), 32'd1);
        check("sub_wr_addr", 32'(wr_addr), 32'd0);
        check("sub_wr_data", wr_data, 32'hCB000000);
        check("sub_err_sticky", 32'(err), 32'd1);

        // Fill to DEPTH with in_valid held high
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req(3'd3, 5'(i), 5'd0, 5'd0, 19'd0);
            tick();
            check($sformatf("fill%0d_wr_en", i), 32'(wr_en), 32'd1);
            check($sformatf("fill%0d_wr_addr", i), 32'(wr_addr), 32'(i));
            check($sformatf("fill%0d_wr_data", i), wr_data, 32'h8B000000 | 32'(i));
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_ready", 32'(in_ready), 32'd0);
        check("fill_count", 32'(count), 32'd4);
        req(3'd3, 5'd9, 5'd0, 5'd0, 19'd0);
        tick();
        check("stall_wr_en", 32'(wr_en), 32'd0);
        check("stall_count", 32'(count), 32'd4);
        check("stall_full", 32'(full), 32'd1);
        tick();
        check("stall2_wr_en", 32'(wr_en), 32'd0);
        in_valid = 1'b0;

        // Reset in the write cycle of an accepted ORR
        do_reset();
        req(3'd7, 5'd0, 5'd0, 5'd0, 19'd0);
        tick();
        req(3'd6, 5'd1, 5'd1, 5'd1, 19'd0);
        tick();
        in_valid = 1'b0;
        check("orr_data", wr_data, 32'hAA010021);
        reset = 1'b1;
        #1;
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        tick();
        reset = 1'b0;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_wr_en_after", 32'(wr_en), 32'd0);

        // Opcode fields of emitted words through the reference control decoder
        check("ctl_ldur", 32'(control_row(w_ldur[31:21])), 32'(9'b011110000));
        check("ctl_stur", 32'(control_row(w_stur[31:21])), 32'(9'b110001000));
        check("ctl_cbz", 32'(control_row(w_cbz[31:21])), 32'(9'b100000101));
        check("ctl_add", 32'(control_row(w_add[31:21])), 32'(9'b000100010));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
